// File: rtl/store_commit_buffer_if.sv
// Bus bundle for the store commit buffer: execute-side writes, ROB commit,
// memory drain port and load-alias query.
interface store_commit_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              i_st_valid;
    logic [TAG_W-1:0]  i_st_tag;
    logic [DATA_W-1:0] i_st_addr;
    logic [DATA_W-1:0] i_st_data;
    logic              i_commit_valid;
    logic [TAG_W-1:0]  i_commit_tag;
    logic              i_drain_en;
    logic [DATA_W-1:0] i_ld_addr;
    logic              o_store_ready;
    logic [DATA_W-1:0] o_mem_address;
    logic [DATA_W-1:0] o_rs2_data;
    logic              o_ld_conflict;
    logic              o_full;
    logic [CW-1:0]     o_count;
    logic              o_overflow;
    logic              o_commit_err;

    modport master (
        output flush, i_st_valid, i_st_tag, i_st_addr, i_st_data,
        output i_commit_valid, i_commit_tag, i_drain_en, i_ld_addr,
        input  o_store_ready, o_mem_address, o_rs2_data,
        input  o_ld_conflict, o_full, o_count, o_overflow, o_commit_err
    );

    modport slave (
        input  flush, i_st_valid, i_st_tag, i_st_addr, i_st_data,
        input  i_commit_valid, i_commit_tag, i_drain_en, i_ld_addr,
        output o_store_ready, o_mem_address, o_rs2_data,
        output o_ld_conflict, o_full, o_count, o_overflow, o_commit_err
    );
endinterface

// File: rtl/store_commit_buffer.sv
// In-order store buffer: holds executed stores until ROB commit, drains
// committed stores to memory, discards speculative ones on flush.
module store_commit_buffer #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    store_commit_buffer_if.slave b
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]  vld_q, vld_d, cmt_q, cmt_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              ovf_q, ovf_d, cerr_q, cerr_d;
    logic              full, wr_en, cm_ok, dr_en;

    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        head_d  = head_q;
        cptr_d  = cptr_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        cmt_d   = cmt_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = '0;
        wr_en = b.i_st_valid && !full && !b.flush;
        cm_ok = b.i_commit_valid && vld_q[cptr_q] && !cmt_q[cptr_q]
                && (tag_q[cptr_q] == b.i_commit_tag);
        dr_en = b.i_drain_en && vld_q[head_q] && cmt_q[head_q];
        ovf_d  = ovf_q | (b.i_st_valid && full);
        cerr_d = cerr_q | (b.i_commit_valid && !cm_ok);
        if (dr_en) begin
            vld_d[head_q] = 1'b0;
            cmt_d[head_q] = 1'b0;
            head_d = head_q + 1'b1;
        end
        if (cm_ok) begin
            cmt_d[cptr_q] = 1'b1;
            cptr_d = cptr_q + 1'b1;
        end
        if (wr_en) begin
            vld_d[tail_q]  = 1'b1;
            cmt_d[tail_q]  = 1'b0;
            tag_d[tail_q]  = b.i_st_tag;
            addr_d[tail_q] = b.i_st_addr;
            data_d[tail_q] = b.i_st_data;
            tail_d = tail_q + 1'b1;
        end
        // Truncate after this cycle's commit so a same-cycle commit survives.
        if (b.flush) begin
            tail_d = cptr_d;
            vld_d  = vld_d & cmt_d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(vld_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            cptr_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            cmt_q   <= '0;
            ovf_q   <= 1'b0;
            cerr_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            cptr_q  <= cptr_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            cmt_q   <= cmt_d;
            ovf_q   <= ovf_d;
            cerr_q  <= cerr_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        b.o_ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i][DATA_W-1:2] == b.i_ld_addr[DATA_W-1:2]))
                b.o_ld_conflict = 1'b1;
        end
    end

    assign b.o_store_ready = dr_en;
    assign b.o_mem_address = dr_en ? addr_q[head_q] : '0;
    assign b.o_rs2_data    = dr_en ? data_q[head_q] : '0;
    assign b.o_full        = full;
    assign b.o_count       = count_q;
    assign b.o_overflow    = ovf_q;
    assign b.o_commit_err  = cerr_q;
endmodule
